mem_port_arbiter: RTL and testbench

- Schedules the single byte-serial memory engine between three requesters: instruction-cache refill (IF), load-store-buffer load (LD) and load-store-buffer store (ST).
- Sits between ICache/LSB and the byte engine. Owns grant selection, the engine start/done handshake, anti-starvation aging, and UART back-pressure for IO stores.
- The engine itself (address/byte sequencing) is outside this block.

---
 rtl/mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single byte-serial memory engine between three requesters:
// instruction-cache refill (IF), load-buffer load (LD) and store (ST).
// It picks a winner, latches the engine command, runs the start/done
// handshake, ages a waiting IF so it cannot starve, and holds IO stores
// while the UART buffer is full.
//
// Optional build macro: ARB_PERF_CNT_EN adds four 32-bit performance
// counters (perf_if_grants, perf_ld_grants, perf_st_grants,
// perf_io_stall_cycles). Without it the ports and counters are absent.
//
// Ports:
//   clk_in, rst_in         clock, synchronous active-low reset
//   rdy_in                 global ready; everything freezes while low
//   clear_in               pipeline flush (aborts IF/LD, never ST)
//   io_buffer_full         UART buffer full, stalls IO stores
//   if_req/if_addr         IF request, if_done pulses when data is valid
//   ld_req/ld_addr/ld_len  load request, ld_done pulses when data is valid
//   st_req/st_addr/st_len/st_wdata  store request, st_done pulses when written
//   rdata                  engine read data captured on the done pulse
//   eng_start/eng_wr/eng_addr/eng_len/eng_wdata  engine command
//   eng_done/eng_rdata     engine completion and read data
//   busy                   high whenever the FSM is not IDLE
module mem_port_arbiter #(
  parameter int         STARVE_LIMIT = 8,
  parameter logic [1:0] IO_ADDR_HI   = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_len,
  output logic        ld_done,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_len,
  input  logic [31:0] st_wdata,
  output logic        st_done,
  output logic [31:0] rdata,
  output logic        eng_start,
  output logic        eng_wr,
  output logic [31:0] eng_addr,
  output logic [1:0]  eng_len,
  output logic [31:0] eng_wdata,
  input  logic        eng_done,
  input  logic [31:0] eng_rdata,
  output logic        busy
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_ld_grants,
  output logic [31:0] perf_st_grants,
  output logic [31:0] perf_io_stall_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_IOHOLD} state_t;
  typedef enum logic [1:0] {G_NONE, G_IF, G_LD, G_ST} grant_t;

  localparam logic [31:0] STARVE_LIM_U = 32'(STARVE_LIMIT);

  state_t     state;
  grant_t     grant;
  grant_t     win;
  grant_t     grant_now;
  logic [3:0] age;
  logic       drop_next;
  logic       if_done_q, ld_done_q, st_done_q, eng_start_q;
  logic       if_eff, ld_eff, st_eff;
  logic       starved;
  logic       st_io_stall;
  logic       abort;

  // A requester keeps its req high during its own done-pulse cycle, so it
  // is masked there; otherwise it would be granted a second time.
  assign if_eff = if_req & ~if_done_q;
  assign ld_eff = ld_req & ~ld_done_q;
  assign st_eff = st_req & ~st_done_q;

  assign starved     = ({28'd0, age} >= STARVE_LIM_U);
  assign st_io_stall = (st_addr[17:16] == IO_ADDR_HI) && io_buffer_full;

  // Flush abandons IF/LD transactions that are past IDLE; stores are
  // committed and never aborted.
  assign abort = clear_in && ((grant == G_IF) || (grant == G_LD)) &&
                 ((state == S_ISSUE) || (state == S_WAIT));

  // Fixed priority ST > LD > IF, except a starved IF jumps the queue.
  always_comb begin
    win = G_NONE;
    if (if_eff && starved)  win = G_IF;
    else if (st_eff)        win = G_ST;
    else if (ld_eff)        win = G_LD;
    else if (if_eff)        win = G_IF;
  end

  // Only a clean IDLE cycle without a flush may hand out a grant.
  assign grant_now = ((state == S_IDLE) && !drop_next && !clear_in) ? win : G_NONE;

  // Pulses are gated with rdy_in so a frozen cycle never shows a pulse, and
  // the start pulse is withdrawn when a flush aborts the grant in ISSUE, so
  // the engine never starts and no stale done has to be dropped.
  assign eng_start = eng_start_q & rdy_in & ~abort;
  assign if_done   = if_done_q & rdy_in;
  assign ld_done   = ld_done_q & rdy_in;
  assign st_done   = st_done_q & rdy_in;
  assign busy      = (state != S_IDLE);

  // Main arbitration FSM, age counter and latched engine command.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= S_IDLE;
      grant       <= G_NONE;
      age         <= 4'd0;
      drop_next   <= 1'b0;
      if_done_q   <= 1'b0;
      ld_done_q   <= 1'b0;
      st_done_q   <= 1'b0;
      eng_start_q <= 1'b0;
      eng_wr      <= 1'b0;
      eng_addr    <= 32'd0;
      eng_len     <= 2'd0;
      eng_wdata   <= 32'd0;
      rdata       <= 32'd0;
    end else if (rdy_in) begin
      if_done_q   <= 1'b0;
      ld_done_q   <= 1'b0;
      st_done_q   <= 1'b0;
      eng_start_q <= 1'b0;

      if (clear_in || !if_req || (grant == G_IF) || (grant_now == G_IF))
        age <= 4'd0;
      else if (age != 4'hF)
        age <= age + 4'd1;

      case (state)
        S_IDLE: begin
          if (drop_next) begin
            // Swallow the completion of the transaction abandoned in WAIT.
            if (eng_done) drop_next <= 1'b0;
          end else if (grant_now != G_NONE) begin
            grant <= grant_now;
            case (grant_now)
              G_ST: begin
                eng_wr    <= 1'b1;
                eng_addr  <= st_addr;
                eng_len   <= st_len;
                eng_wdata <= st_wdata;
              end
              G_LD: begin
                eng_wr    <= 1'b0;
                eng_addr  <= ld_addr;
                eng_len   <= ld_len;
                eng_wdata <= 32'd0;
              end
              default: begin
                eng_wr    <= 1'b0;
                eng_addr  <= if_addr;
                eng_len   <= 2'd3;
                eng_wdata <= 32'd0;
              end
            endcase
            if ((grant_now == G_ST) && st_io_stall) begin
              state <= S_IOHOLD;
            end else begin
              state       <= S_ISSUE;
              eng_start_q <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (abort) begin
            state <= S_IDLE;
            grant <= G_NONE;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (abort) begin
            state     <= S_IDLE;
            grant     <= G_NONE;
            // A done arriving in the flush cycle itself is already consumed.
            drop_next <= ~eng_done;
          end else if (eng_done) begin
            case (grant)
              G_IF:    if_done_q <= 1'b1;
              G_LD:    ld_done_q <= 1'b1;
              G_ST:    st_done_q <= 1'b1;
              default: ;
            endcase
            rdata <= eng_rdata;
            state <= S_IDLE;
            grant <= G_NONE;
          end
        end

        S_IOHOLD: begin
          if (!io_buffer_full) begin
            state       <= S_ISSUE;
            eng_start_q <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          grant <= G_NONE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic   enter_issue;
  grant_t issue_who;

  assign issue_who   = (state == S_IOHOLD) ? G_ST : grant_now;
  assign enter_issue = ((grant_now != G_NONE) && !((grant_now == G_ST) && st_io_stall)) ||
                       ((state == S_IOHOLD) && !io_buffer_full);

  // Performance counters: grants counted on ISSUE entry, IO stalls per
  // IOHOLD cycle. They wrap naturally and ignore flushes.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      perf_if_grants       <= 32'd0;
      perf_ld_grants       <= 32'd0;
      perf_st_grants       <= 32'd0;
      perf_io_stall_cycles <= 32'd0;
    end else if (rdy_in) begin
      if (enter_issue) begin
        case (issue_who)
          G_IF:    perf_if_grants <= perf_if_grants + 32'd1;
          G_LD:    perf_ld_grants <= perf_ld_grants + 32'd1;
          G_ST:    perf_st_grants <= perf_st_grants + 32'd1;
          default: ;
        endcase
      end
      if (state == S_IOHOLD)
        perf_io_stall_cycles <= perf_io_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. A single thread drives all inputs
// one cycle at a time through applyStimulus, which also plays the memory
// engine (fixed latency, optional) and the requesters (drop req on done).
// Every engine start is logged so grant order and spacing can be compared
// against hand-computed sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, clear_in, io_buffer_full;
  logic        if_req, ld_req, st_req;
  logic [31:0] if_addr, ld_addr, st_addr, st_wdata;
  logic [1:0]  ld_len, st_len;
  logic        if_done, ld_done, st_done;
  logic [31:0] rdata;
  logic        eng_start, eng_wr;
  logic [31:0] eng_addr, eng_wdata;
  logic [1:0]  eng_len;
  logic        eng_done;
  logic [31:0] eng_rdata;
  logic        busy;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants, perf_ld_grants, perf_st_grants, perf_io_stall_cycles;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          eng_auto;
  bit          auto_drop;
  int          eng_lat;
  int          eng_cnt;
  logic [31:0] auto_rdata;
  logic [31:0] g_addr [32];
  logic [31:0] g_wdata[32];
  logic        g_wr   [32];
  logic [1:0]  g_len  [32];
  int          g_cyc  [32];
  int          g_n;
  int          n_if_done, n_ld_done, n_st_done;
  logic [31:0] ld_rdata_seen;
  bit          st_seen;

  mem_port_arbiter #(.STARVE_LIMIT(8), .IO_ADDR_HI(2'b11)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done),
    .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_wdata(st_wdata),
    .st_done(st_done), .rdata(rdata),
    .eng_start(eng_start), .eng_wr(eng_wr), .eng_addr(eng_addr),
    .eng_len(eng_len), .eng_wdata(eng_wdata),
    .eng_done(eng_done), .eng_rdata(eng_rdata), .busy(busy)
`ifdef ARB_PERF_CNT_EN
    , .perf_if_grants(perf_if_grants), .perf_ld_grants(perf_ld_grants),
    .perf_st_grants(perf_st_grants), .perf_io_stall_cycles(perf_io_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Advance n cycles; outputs are sampled 1 time unit after each rising
  // edge, then the engine and requester models react for the new cycle.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      eng_done = 1'b0;
      if (eng_auto) begin
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            eng_done  = 1'b1;
            eng_rdata = auto_rdata;
          end
        end
        if (eng_start) eng_cnt = eng_lat;
      end
      if (eng_start && g_n < 32) begin
        g_addr[g_n]  = eng_addr;
        g_wdata[g_n] = eng_wdata;
        g_wr[g_n]    = eng_wr;
        g_len[g_n]   = eng_len;
        g_cyc[g_n]   = cyc;
        g_n++;
      end
      if (if_done) begin
        n_if_done++;
        if (auto_drop) if_req = 1'b0;
      end
      if (ld_done) begin
        n_ld_done++;
        ld_rdata_seen = rdata;
        if (auto_drop) ld_req = 1'b0;
      end
      if (st_done) begin
        n_st_done++;
        if (auto_drop) st_req = 1'b0;
      end
    end
  endtask

  task automatic clearLog();
    g_n = 0;
    n_if_done = 0;
    n_ld_done = 0;
    n_st_done = 0;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    if_addr = 32'd0; ld_addr = 32'd0; st_addr = 32'd0; st_wdata = 32'd0;
    ld_len = 2'd0; st_len = 2'd0;
    eng_done = 1'b0; eng_rdata = 32'd0;
    eng_auto = 1'b1; auto_drop = 1'b1; eng_lat = 1; eng_cnt = 0;
    auto_rdata = 32'd0; ld_rdata_seen = 32'd0; st_seen = 1'b0;
    clearLog();

    // Reset state
    applyStimulus(3);
    checkOutput("rst_busy",   busy, 0);
    checkOutput("rst_start",  eng_start, 0);
    checkOutput("rst_addr",   eng_addr, 0);
    checkOutput("rst_len",    eng_len, 0);
    checkOutput("rst_wr",     eng_wr, 0);
    checkOutput("rst_wdata",  eng_wdata, 0);
    checkOutput("rst_dones",  {if_done, ld_done, st_done}, 0);
    checkOutput("rst_rdata",  rdata, 0);
    rst_in = 1'b1;
    applyStimulus(1);

    // Test 1: all three requesters at once -> ST, LD, IF
    clearLog();
    auto_rdata = 32'hCAFE_0001;
    st_req = 1'b1; st_addr = 32'h100; st_len = 2'd3; st_wdata = 32'h1122_3344;
    ld_req = 1'b1; ld_addr = 32'h200; ld_len = 2'd1;
    if_req = 1'b1; if_addr = 32'h300;
    applyStimulus(1);
    checkOutput("t1_start_latency", eng_start, 1);
    checkOutput("t1_first_wr",      eng_wr, 1);
    checkOutput("t1_first_addr",    eng_addr, 32'h100);
    checkOutput("t1_first_wdata",   eng_wdata, 32'h1122_3344);
    applyStimulus(15);
    checkOutput("t1_grants",   g_n, 3);
    checkOutput("t1_g1_addr",  g_addr[1], 32'h200);
    checkOutput("t1_g1_len",   g_len[1], 1);
    checkOutput("t1_g2_addr",  g_addr[2], 32'h300);
    checkOutput("t1_g2_len",   g_len[2], 3);
    checkOutput("t1_g2_wr",    g_wr[2], 0);
    checkOutput("t1_gap01",    g_cyc[1] - g_cyc[0], 3);
    checkOutput("t1_gap12",    g_cyc[2] - g_cyc[1], 3);
    checkOutput("t1_dones",    {n_st_done[7:0], n_ld_done[7:0], n_if_done[7:0]}, 32'h0001_0101);
    checkOutput("t1_ld_rdata", ld_rdata_seen, 32'hCAFE_0001);
    checkOutput("t1_idle",     busy, 0);

    // Test 2: ST and LD held continuously, IF must win by aging
    clearLog();
    auto_drop = 1'b0;
    st_req = 1'b1; st_addr = 32'h110; st_len = 2'd3; st_wdata = 32'd0;
    ld_req = 1'b1; ld_addr = 32'h210; ld_len = 2'd0;
    if_req = 1'b1; if_addr = 32'h310;
    applyStimulus(11);
    checkOutput("t2_grants",  g_n, 4);
    checkOutput("t2_g0_addr", g_addr[0], 32'h110);
    checkOutput("t2_g1_addr", g_addr[1], 32'h210);
    checkOutput("t2_g2_addr", g_addr[2], 32'h110);
    checkOutput("t2_if_addr", g_addr[3], 32'h310);
    checkOutput("t2_if_len",  g_len[3], 3);
    auto_drop = 1'b1;
    applyStimulus(30);
    checkOutput("t2_drained", busy, 0);

    // Test 3: IO store held while the UART buffer is full
    clearLog();
    st_req = 1'b1; st_addr = 32'h0003_0000; st_len = 2'd0; st_wdata = 32'h55AA_55AA;
    io_buffer_full = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("t3_hold%0d_start", i), eng_start, 0);
      checkOutput($sformatf("t3_hold%0d_busy", i), busy, 1);
      if (i == 2) begin
        ld_req = 1'b1; ld_addr = 32'h220; ld_len = 2'd3;
      end
    end
    io_buffer_full = 1'b0;
    applyStimulus(1);
    checkOutput("t3_start", eng_start, 1);
    checkOutput("t3_wr",    eng_wr, 1);
    checkOutput("t3_addr",  eng_addr, 32'h0003_0000);
    checkOutput("t3_wdata", eng_wdata, 32'h55AA_55AA);
    applyStimulus(12);
    checkOutput("t3_st_done",  n_st_done, 1);
    checkOutput("t3_grants",   g_n, 2);
    checkOutput("t3_ld_after", g_addr[1], 32'h220);
    checkOutput("t3_idle",     busy, 0);

    // Test 4: flush during an LD in WAIT, stale done must be swallowed
    clearLog();
    eng_auto = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h400; ld_len = 2'd3;
    applyStimulus(1);
    checkOutput("t4_ld_start", eng_start, 1);
    applyStimulus(1);
    clear_in = 1'b1; ld_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h500;
    applyStimulus(1);
    clear_in = 1'b0;
    checkOutput("t4_abandoned", busy, 0);
    applyStimulus(2);
    checkOutput("t4_no_grant_during_drop", g_n, 1);
    eng_done = 1'b1; eng_rdata = 32'hBADB_AD00;
    applyStimulus(1);
    checkOutput("t4_swallow_start", eng_start, 0);
    checkOutput("t4_no_ld_done",    n_ld_done, 0);
    applyStimulus(1);
    checkOutput("t4_if_start", eng_start, 1);
    checkOutput("t4_if_addr",  eng_addr, 32'h500);
    checkOutput("t4_if_len",   eng_len, 3);
    applyStimulus(1);
    eng_done = 1'b1; eng_rdata = 32'h1234_5678;
    applyStimulus(1);
    checkOutput("t4_if_done",  if_done, 1);
    checkOutput("t4_if_rdata", rdata, 32'h1234_5678);
    checkOutput("t4_ld_never", n_ld_done, 0);
    applyStimulus(2);

    // Test 5: flush during a store in WAIT does not abort it
    clearLog();
    eng_auto = 1'b1; eng_lat = 3;
    st_req = 1'b1; st_addr = 32'h1000; st_len = 2'd3; st_wdata = 32'hDEAD_BEEF;
    applyStimulus(1);
    checkOutput("t5_start", eng_start, 1);
    applyStimulus(1);
    clear_in = 1'b1; st_wdata = 32'd0;
    applyStimulus(1);
    clear_in = 1'b0;
    checkOutput("t5_still_busy", busy, 1);
    checkOutput("t5_wdata",      eng_wdata, 32'hDEAD_BEEF);
    st_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      checkOutput("t5_wdata_hold", eng_wdata, 32'hDEAD_BEEF);
      if (st_done) begin
        st_seen = 1'b1;
        break;
      end
    end
    checkOutput("t5_st_done_seen", st_seen, 1);
    checkOutput("t5_st_done_cnt",  n_st_done, 1);
    applyStimulus(2);
    checkOutput("t5_idle", busy, 0);

    // Test 6: rdy_in low freezes WAIT, then reset mid-WAIT
    clearLog();
    eng_auto = 1'b0; eng_lat = 1;
    ld_req = 1'b1; ld_addr = 32'h600; ld_len = 2'd1;
    applyStimulus(2);
    rdy_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1);
      checkOutput("t6_frozen_busy", busy, 1);
      checkOutput("t6_frozen_addr", eng_addr, 32'h600);
      checkOutput("t6_frozen_len",  eng_len, 1);
      checkOutput("t6_frozen_done", ld_done, 0);
    end
    applyStimulus(1);
    checkOutput("t6_frozen_busy3", busy, 1);
    rdy_in = 1'b1;
    eng_done = 1'b1; eng_rdata = 32'h0000_0077;
    applyStimulus(1);
    checkOutput("t6_ld_done",  ld_done, 1);
    checkOutput("t6_ld_rdata", rdata, 32'h0000_0077);
    st_req = 1'b1; st_addr = 32'h800; st_len = 2'd3; st_wdata = 32'h0000_0001;
    applyStimulus(1);
    checkOutput("t6_st_start", eng_start, 1);
    applyStimulus(1);
    rst_in = 1'b0;
    applyStimulus(1);
    checkOutput("t6_rst_busy",  busy, 0);
    checkOutput("t6_rst_addr",  eng_addr, 0);
    checkOutput("t6_rst_wdata", eng_wdata, 0);
    checkOutput("t6_rst_wr",    eng_wr, 0);
    checkOutput("t6_rst_len",   eng_len, 0);
    checkOutput("t6_rst_rdata", rdata, 0);
    checkOutput("t6_rst_pulse", {eng_start, if_done, ld_done, st_done}, 0);
    rst_in = 1'b1; st_req = 1'b0;
    applyStimulus(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
